// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester Wishbone classic arbiter sharing one
// data-memory port. Whole bus cycles are granted round-robin. Every
// acknowledged or errored transfer is followed by one POST cycle in which
// the address, select, data and write-enable stay stable for the memory's
// delayed store commit.
// Optional watchdog: define ARB_TIMEOUT_EN to terminate transfers the memory
// never answers after TimeoutCycles stalled strobe cycles.
module data_memory_arbiter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_POST   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [1:0]  w_arb;
    logic        r_last;
    logic        r_hold_we;
    logic [3:0]  r_hold_sel;
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_wdata;

    logic        w_in_grant;
    logic        w_own1;
    logic        w_own_cyc;
    logic        w_own_stb;
    logic        w_own_we;
    logic [3:0]  w_own_sel;
    logic [31:0] w_own_addr;
    logic [31:0] w_own_wdata;
    logic        w_timeout;
    logic        w_resp;

    assign w_in_grant  = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
    assign w_own1      = (r_state == ST_GRANT1);
    assign w_own_cyc   = w_own1 ? m1_cyc   : m0_cyc;
    assign w_own_stb   = w_own1 ? m1_stb   : m0_stb;
    assign w_own_we    = w_own1 ? m1_we    : m0_we;
    assign w_own_sel   = w_own1 ? m1_sel   : m0_sel;
    assign w_own_addr  = w_own1 ? m1_addr  : m0_addr;
    assign w_own_wdata = w_own1 ? m1_wdata : m0_wdata;
    assign w_resp      = w_in_grant && (s_ack || s_err || w_timeout);

    // Round-robin pick applied whenever the bus is free (IDLE and POST)
    always_comb begin
        w_arb = ST_IDLE;
        if (m0_cyc && m1_cyc) begin
            w_arb = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_cyc) begin
            w_arb = ST_GRANT0;
        end else if (m1_cyc) begin
            w_arb = ST_GRANT1;
        end
    end

    // Next state: a response ends the grant via POST, a dropped cyc hands over directly
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_GRANT0: begin
                if (w_resp) begin
                    w_next = ST_POST;
                end else if (!m0_cyc) begin
                    w_next = m1_cyc ? ST_GRANT1 : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (w_resp) begin
                    w_next = ST_POST;
                end else if (!m1_cyc) begin
                    w_next = m0_cyc ? ST_GRANT0 : ST_IDLE;
                end
            end
            default: w_next = w_arb;
        endcase
    end

    // State, round-robin history and the post-acknowledge hold registers
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b1;
            r_hold_we    <= 1'b0;
            r_hold_sel   <= '0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_grant && (w_next != r_state)) begin
                r_last <= w_own1;
            end
            if (w_resp) begin
                r_hold_addr  <= w_own_addr;
                r_hold_sel   <= w_own_sel;
                r_hold_wdata <= w_own_wdata;
                // An errored or abandoned transfer must never commit a store
                r_hold_we    <= w_own_we & ~s_err & ~w_timeout;
            end
        end
    end

    // Memory-side outputs: owner pass-through while granted, held values in POST
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_addr  = '0;
        s_wdata = '0;
        grant   = 2'b00;
        case (r_state)
            ST_GRANT0, ST_GRANT1: begin
                s_cyc   = w_own_cyc;
                s_stb   = w_own_cyc & w_own_stb;
                s_we    = w_own_we;
                s_sel   = w_own_sel;
                s_addr  = w_own_addr;
                s_wdata = w_own_wdata;
                grant   = w_own1 ? 2'b10 : 2'b01;
            end
            ST_POST: begin
                s_we    = r_hold_we;
                s_sel   = r_hold_sel;
                s_addr  = r_hold_addr;
                s_wdata = r_hold_wdata;
                grant   = r_last ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // Response routing: only the current owner sees ack/err/rdata; err wins over ack
    always_comb begin
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        if (r_state == ST_GRANT0) begin
            m0_ack   = s_ack & ~s_err & ~w_timeout;
            m0_err   = s_err | w_timeout;
            m0_rdata = s_rdata;
        end
        if (r_state == ST_GRANT1) begin
            m1_ack   = s_ack & ~s_err & ~w_timeout;
            m1_err   = s_err | w_timeout;
            m1_rdata = s_rdata;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_wdt_cnt;
    logic        w_stalled;

    assign w_stalled = w_in_grant && s_stb && !s_ack && !s_err;
    assign w_timeout = w_stalled && (r_wdt_cnt == 16'(TimeoutCycles - 1));

    // Count stalled strobe cycles of the current grant; responses and handovers restart it
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_wdt_cnt <= '0;
        end else if (w_stalled && (w_next == r_state)) begin
            r_wdt_cnt <= r_wdt_cnt + 16'd1;
        end else if (!w_in_grant || s_ack || s_err || w_timeout || (w_next != r_state)) begin
            r_wdt_cnt <= '0;
        end
    end
`else
    logic [15:0] w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = 16'(TimeoutCycles);
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a registered-ack memory with a delayed store
// commit, directed scenarios and random two-requester traffic checked against
// a round-robin ownership model and a word-array memory model.
module tb_data_memory_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam logic [31:0] ERR_ADDR = 32'h0000_3002;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_cyc, s_stb, s_we, s_ack, s_err;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    logic        drv_cyc [2];
    txn_t        cur [2];
    txn_t        q0 [$];
    txn_t        q1 [$];

    logic [31:0] dev_mem [16];
    logic        mem_ack, mem_err, mem_commit, mem_stall;
    logic [31:0] mem_rdata;

    logic [31:0] exp_mem [16];
    int          exp_last;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk_in = ~clk_in;

    assign m0_cyc   = drv_cyc[0];
    assign m0_stb   = drv_cyc[0];
    assign m0_we    = cur[0].we;
    assign m0_sel   = cur[0].sel;
    assign m0_addr  = cur[0].addr;
    assign m0_wdata = cur[0].wdata;
    assign m1_cyc   = drv_cyc[1];
    assign m1_stb   = drv_cyc[1];
    assign m1_we    = cur[1].we;
    assign m1_sel   = cur[1].sel;
    assign m1_addr  = cur[1].addr;
    assign m1_wdata = cur[1].wdata;
    assign s_ack    = mem_ack;
    assign s_err    = mem_err;
    assign s_rdata  = mem_rdata;

    data_memory_arbiter #(.TimeoutCycles(8)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_sel   (m0_sel),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_sel   (m1_sel),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_sel    (s_sel),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .s_rdata  (s_rdata),
        .grant    (grant)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'hDEAD_BEEF;
        return 32'h1000_0000 ^ (32'(i) * 32'h0103_0507);
    endfunction

    function automatic logic [31:0] oh(input int n);
        return (n == 0) ? 32'd1 : 32'd2;
    endfunction

    // Memory device: registered ack one cycle after sampling stb, store committed one cycle after ack
    always @(posedge clk_in) begin
        if (!reset_in) begin
            mem_ack    <= 1'b0;
            mem_err    <= 1'b0;
            mem_commit <= 1'b0;
            mem_rdata  <= '0;
            for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
        end else begin
            mem_ack    <= 1'b0;
            mem_err    <= 1'b0;
            mem_commit <= mem_ack;
            if (mem_commit && s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) dev_mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
            if (s_cyc && s_stb && !mem_ack && !mem_err && !mem_stall) begin
                if (s_addr == ERR_ADDR) begin
                    mem_err <= 1'b1;
                end else begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= dev_mem[s_addr[5:2]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input int n, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.sel = sel; t.addr = addr; t.wdata = wdata;
        if (n == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    task automatic push_rand(input int n, input int count);
        for (int i = 0; i < count; i++)
            push(n, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 32'h3000 + (32'($urandom_range(0, 15)) << 2), $urandom);
    endtask

    task automatic load_next(input int n);
        if (n == 0 && q0.size() > 0) begin
            cur[0] = q0.pop_front(); drv_cyc[0] = 1'b1;
        end else if (n == 1 && q1.size() > 0) begin
            cur[1] = q1.pop_front(); drv_cyc[1] = 1'b1;
        end else begin
            drv_cyc[n] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        reset_in = 1'b0;
        drv_cyc[0] = 1'b0; drv_cyc[1] = 1'b0;
        mem_stall = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_s_bus", 32'({s_cyc, s_stb, s_we, s_sel}), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_m_resp", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
        chk("rst_m_rdata", m0_rdata | m1_rdata, 32'd0);
        reset_in = 1'b1;
        exp_last = 1;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    endtask

    // Drive both queues to completion; each completion is checked against the ownership model
    task automatic run_queues();
        int   cycles, exp_next, post_n, gnext_n, idx;
        bit   post_pend, grant_pend, gnext_valid, more;
        bit   done [2];
        logic a [2];
        logic e [2];
        logic [31:0] rd [2];
        logic exp_err;
        txn_t post_t;
        cycles = 0; post_n = 0; gnext_n = 0;
        post_pend = 0; grant_pend = 0; gnext_valid = 0;
        post_t = '0;
        @(posedge clk_in); #1;
        if (q0.size() > 0 && q1.size() > 0) exp_next = 1 - exp_last;
        else if (q0.size() > 0)             exp_next = 0;
        else                                exp_next = 1;
        load_next(0); load_next(1);
        while ((drv_cyc[0] || drv_cyc[1] || post_pend || grant_pend) && cycles < 500) begin
            @(negedge clk_in);
            cycles++;
            done[0] = 0; done[1] = 0;
            a[0] = m0_ack; e[0] = m0_err; rd[0] = m0_rdata;
            a[1] = m1_ack; e[1] = m1_err; rd[1] = m1_rdata;
            if (grant_pend) begin
                chk("handover_grant", 32'(grant), oh(gnext_n));
                grant_pend = 0;
            end
            if (post_pend) begin
                chk("post_cyc_stb", 32'({s_cyc, s_stb}), 32'd0);
                chk("post_addr", s_addr, post_t.addr);
                chk("post_sel", 32'(s_sel), 32'(post_t.sel));
                chk("post_wdata", s_wdata, post_t.wdata);
                chk("post_we", 32'(s_we), 32'(post_t.we));
                chk("post_grant", 32'(grant), oh(post_n));
                chk("post_no_resp", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
                post_pend = 0;
                if (gnext_valid) begin grant_pend = 1; gnext_valid = 0; end
            end
            for (int n = 0; n < 2; n++) begin
                if (a[n] || e[n]) begin
                    exp_err = (cur[n].addr == ERR_ADDR);
                    idx = int'(cur[n].addr[5:2]);
                    chk("resp_is_err", 32'(e[n]), 32'(exp_err));
                    chk("owner", 32'(n), 32'(exp_next));
                    chk("resp_grant", 32'(grant), oh(n));
                    chk("other_quiet", 32'({a[1-n], e[1-n]}), 32'd0);
                    chk("other_rdata", rd[1-n], 32'd0);
                    if (!cur[n].we && !exp_err) chk("rdata", rd[n], exp_mem[idx]);
                    if (cur[n].we && !exp_err)
                        for (int b = 0; b < 4; b++)
                            if (cur[n].sel[b]) exp_mem[idx][8*b +: 8] = cur[n].wdata[8*b +: 8];
                    post_t = cur[n];
                    post_t.we = cur[n].we & ~exp_err;
                    post_n = n;
                    post_pend = 1;
                    exp_last = n;
                    more = (n == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (drv_cyc[1-n]) begin
                        exp_next = 1 - n; gnext_n = 1 - n; gnext_valid = 1;
                    end else if (more) begin
                        exp_next = n; gnext_n = n; gnext_valid = 1;
                    end else begin
                        gnext_valid = 0;
                    end
                    done[n] = 1;
                end
            end
            if (done[0] || done[1]) begin
                @(posedge clk_in); #1;
                if (done[0]) load_next(0);
                if (done[1]) load_next(1);
            end
        end
        if (cycles >= 500) chk("run_budget", 32'(cycles), 32'd0);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        int k;
        drv_cyc[0] = 1'b0; drv_cyc[1] = 1'b0;
        cur[0] = '0; cur[1] = '0;
        mem_stall = 1'b0;
        exp_last = 1;

        reset_dut();

        // Single read of the preset word at 0x3000
        push(0, 1'b0, 4'hF, 32'h3000, 32'h0);
        run_queues();
        chk("single_read_model", exp_mem[0], 32'hDEAD_BEEF);

        // Tie straight after reset: requester 0 first, then requester 1
        reset_dut();
        push(0, 1'b0, 4'hF, 32'h3008, 32'h0);
        push(1, 1'b0, 4'hF, 32'h300C, 32'h0);
        run_queues();

        // Back-to-back fairness with four random transfers each
        push_rand(0, 4);
        push_rand(1, 4);
        run_queues();

        // Partial write then readback from requester 1
        push(1, 1'b1, 4'b0011, 32'h3004, 32'hA5A5_A5A5);
        push(1, 1'b0, 4'hF, 32'h3004, 32'h0);
        run_queues();
        chk("write_merge", exp_mem[1], {init_word(1) >> 16, 16'hA5A5});

        // Errored write: err to requester 0, no store held in POST
        push(0, 1'b1, 4'hF, ERR_ADDR, 32'h1234_5678);
        push(0, 1'b0, 4'hF, 32'h3000, 32'h0);
        run_queues();

        // Random mixed traffic
        for (int r = 0; r < 10; r++) begin
            push_rand(0, $urandom_range(0, 3));
            push_rand(1, $urandom_range(0, 3));
            run_queues();
        end

`ifdef ARB_TIMEOUT_EN
        // Watchdog: memory never answers, err on the 8th stalled cycle
        mem_stall = 1'b1;
        @(posedge clk_in); #1;
        cur[0] = {1'b1, 4'hF, 32'h3010, 32'hCAFE_F00D};
        drv_cyc[0] = 1'b1;
        k = 0;
        @(negedge clk_in);
        while (grant !== 2'b01 && k < 10) begin @(negedge clk_in); k++; end
        chk("wdt_grant", 32'(grant), 32'd1);
        for (int c = 1; c < 8; c++) begin
            chk("wdt_quiet", 32'(m0_err), 32'd0);
            @(negedge clk_in);
        end
        chk("wdt_err", 32'(m0_err), 32'd1);
        @(posedge clk_in); #1;
        drv_cyc[0] = 1'b0;
        @(negedge clk_in);
        chk("wdt_post_cyc", 32'(s_cyc), 32'd0);
        chk("wdt_post_we", 32'(s_we), 32'd0);
        chk("wdt_post_grant", 32'(grant), 32'd1);
        chk("wdt_post_err", 32'(m0_err), 32'd0);
        @(negedge clk_in);
        chk("wdt_idle_grant", 32'(grant), 32'd0);
        mem_stall = 1'b0;
        exp_last = 0;
        @(negedge clk_in);
`endif

        // Reset asserted while requester 1 holds a stalled grant
        mem_stall = 1'b1;
        @(posedge clk_in); #1;
        cur[1] = {1'b1, 4'hF, 32'h3014, 32'h0BAD_0BAD};
        drv_cyc[1] = 1'b1;
        k = 0;
        @(negedge clk_in);
        while (grant !== 2'b10 && k < 10) begin @(negedge clk_in); k++; end
        chk("stall_grant1", 32'(grant), 32'd2);
        repeat (4) begin
            @(negedge clk_in);
            chk("stall_holds", 32'({grant, m1_ack, m1_err}), 32'b1000);
        end
        #2 reset_in = 1'b0;
        #1;
        chk("async_rst_bus", 32'({s_cyc, s_stb, s_we, s_sel}), 32'd0);
        chk("async_rst_addr", s_addr | s_wdata, 32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        drv_cyc[1] = 1'b0;
        mem_stall = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;
        exp_last = 1;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);

        // Recovery: tie resolved as after a fresh reset
        push(0, 1'b0, 4'hF, 32'h3014, 32'h0);
        push(1, 1'b0, 4'hF, 32'h3000, 32'h0);
        run_queues();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester Wishbone classic arbiter that shares the single data-memory secondary port between the CPU data port (requester 0) and a second requester such as a DMA or debug port (requester 1). It sits between the two primaries and the memory, grants whole bus cycles round-robin, and routes ack/err/rdata back to the granted requester only. It also enforces a one-cycle post-acknowledge hold, because the memory commits stores in the cycle after ack. An optional watchdog terminates transfers the memory never answers.

## Interface
- TimeoutCycles, 255: cycles with stb high and no ack/err before the watchdog fires (only with ARB_TIMEOUT_EN); valid range 1..65535.
- clk_in  in  1  clock; all state changes on rising edge.
- reset_in  in  1  reset; asynchronous, active-low.
- m0_cyc, m0_stb, m0_we  in  1 each  requester 0 cycle, strobe, write enable.
- m0_sel  in  4  requester 0 byte selects.
- m0_addr, m0_wdata  in  32 each  requester 0 address, write data.
- m0_ack, m0_err  out  1 each  requester 0 acknowledge, error.
- m0_rdata  out  32  requester 0 read data.
- m1_*  same set and widths as m0_*  requester 1.
- s_cyc, s_stb, s_we  out  1 each  to memory.
- s_sel  out  4  to memory.
- s_addr, s_wdata  out  32 each  to memory.
- s_ack, s_err  in  1 each  from memory.
- s_rdata  in  32  from memory.
- grant  out  2  one-hot current owner; 2'b00 when no requester owns the bus.

## Operation
- States: IDLE, GRANT0, GRANT1, POST. A `last` bit records the most recently granted requester; reset value is 1, so requester 0 wins the first tie.
- IDLE:
  - Drives s_cyc = s_stb = s_we = 0, s_sel = 0, s_addr = 0, s_wdata = 0, grant = 0.
  - If exactly one mN_cyc is high, go to GRANTN.
  - If both are high, go to the GRANT state of the requester that is not `last`.
- GRANTn:
  - Slave outputs carry mn_* combinationally. grant bit n = 1.
  - s_ack, s_err and s_rdata go to mn_*; the other requester sees ack = 0, err = 0, rdata = 0.
  - On s_ack or s_err: latch s_addr, s_sel, s_wdata and s_we into hold registers. On s_err, latch s_we as 0. Set `last` = n and go to POST.
  - If mn_cyc drops with no ack/err pending: set `last` = n. Go to GRANT of the other requester if its cyc is high, else to IDLE.
- POST (exactly one cycle):
  - s_cyc = s_stb = 0.
  - s_addr, s_sel, s_wdata and s_we come from the hold registers, so the memory's write commit sees stable inputs.
  - No ack/err is forwarded. grant holds the previous owner.
  - Exit with the IDLE arbitration rules, using the updated `last`. A requester that keeps cyc high for back-to-back transfers therefore alternates with a waiting peer.
- A requester's stb is never forwarded while the other requester owns the bus or during POST; it waits without ack.
- Reset mid-transfer forces IDLE. All outputs go to 0 and `last` goes to 1 immediately (asynchronously).

## Timing
- Reset values: every output is 0; state = IDLE; hold registers = 0; watchdog counter = 0.
- Arbitration latency is 1 cycle. A request sampled at edge k appears on s_stb after edge k.
- With a registered-ack memory, the single-transfer sequence is:
  - edge k: grant.
  - edge k+1: memory samples stb.
  - cycle after edge k+1: s_ack/m_ack high for one cycle.
  - edge k+2: enter POST.
  - edge k+3: next arbitration.
- ack/err to requesters is combinational from s_ack/s_err in GRANT states: zero added latency.
- Both requesters asserting cyc at the same edge is resolved purely by `last`. Simultaneous s_ack and s_err is treated as err.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: a 16-bit counter increments each GRANT cycle with s_stb high and neither s_ack nor s_err. It clears on ack, on err, and on leaving GRANT.
- When the count reaches TimeoutCycles:
  - mn_err pulses for one cycle and the counter clears.
  - Hold registers latch with s_we = 0, and the state goes to POST.
  - A late s_ack is then ignored.
- Not defined: no counter; a stalled memory holds the grant indefinitely.

## Test plan
- Single read: m0 reads 0x3000, memory returns 0xDEADBEEF -> m0_rdata = 0xDEADBEEF with m0_ack for 1 cycle; m1_ack stays 0; one POST cycle follows, with s_cyc = 0 and s_addr = 0x3000.
- Tie after reset: m0 and m1 assert cyc at the same edge -> grant = 01 first, grant = 10 for the second transfer; m1 receives no ack during m0's transfer.
- Back-to-back fairness: both hold cyc for 4 transfers each -> grants alternate 0,1,0,1,… and each handover includes exactly one POST cycle.
- Write hold: m1 writes 0xA5A5A5A5 with sel = 4'b0011 to 0x3004 -> during POST, s_addr = 0x3004, s_we = 1 and s_wdata = 0xA5A5A5A5; readback gives the upper 16 bits unchanged and the lower 16 bits = 0xA5A5.
- Error and reset: m0 addresses 0x3002 and memory asserts s_err -> m0_err for 1 cycle and s_we = 0 in POST. A separate run asserts reset_in low mid-GRANT1 -> outputs 0 and grant = 00 without waiting for a clock edge.
- Timeout (ARB_TIMEOUT_EN, TimeoutCycles = 8): the memory never acks -> m0_err is high on the 8th stalled cycle, followed by POST with s_we = 0 and then IDLE.
